// File: rtl/e1000_eeprom_pkg.sv
// Shared definitions for the e1000 EEPROM path: word offsets of the
// auto-loaded image, EERD register field positions and the auto-load FSM states.
package e1000_eeprom_pkg;

    // EEPROM word offsets captured into result registers during auto-load
    localparam logic [7:0] WORD_MAC0       = 8'h00;
    localparam logic [7:0] WORD_MAC1       = 8'h01;
    localparam logic [7:0] WORD_MAC2       = 8'h02;
    localparam logic [7:0] WORD_INIT_CTRL1 = 8'h0A;
    localparam logic [7:0] WORD_SUBSYS_ID  = 8'h0B;
    localparam logic [7:0] WORD_SUBSYS_VEN = 8'h0C;
    localparam logic [7:0] WORD_DEV_ID     = 8'h0D;
    localparam logic [7:0] WORD_VEN_ID     = 8'h0E;
    localparam logic [7:0] WORD_INIT_CTRL2 = 8'h0F;

    // Sum of all image words a valid EEPROM must produce
    localparam logic [15:0] CHECKSUM_DEFAULT = 16'hBABA;

    // EERD register field positions
    localparam int EERD_START_BIT = 0;
    localparam int EERD_DONE_BIT  = 4;
    localparam int EERD_ADDR_LSB  = 8;
    localparam int EERD_ADDR_MSB  = 15;
    localparam int EERD_DATA_LSB  = 16;
    localparam int EERD_DATA_MSB  = 31;

    // Result register slots (index into the result array)
    localparam int NUM_RESULTS      = 9;
    localparam int SLOT_MAC0        = 0;
    localparam int SLOT_MAC1        = 1;
    localparam int SLOT_MAC2        = 2;
    localparam int SLOT_INIT_CTRL1  = 3;
    localparam int SLOT_SUBSYS_ID   = 4;
    localparam int SLOT_SUBSYS_VEN  = 5;
    localparam int SLOT_DEV_ID      = 6;
    localparam int SLOT_VEN_ID      = 7;
    localparam int SLOT_INIT_CTRL2  = 8;
    localparam logic [3:0] SLOT_NONE = 4'hF;

    typedef enum logic [2:0] {
        AL_ISSUE,
        AL_ACK,
        AL_WAIT,
        AL_NEXT,
        IDLE,
        H_ISSUE,
        H_ACK,
        H_WAIT
    } eeprom_state_e;

    // Map an EEPROM word index to its result slot, SLOT_NONE if not kept
    function automatic logic [3:0] result_slot(input logic [7:0] word_idx);
        case (word_idx)
            WORD_MAC0:       return 4'(SLOT_MAC0);
            WORD_MAC1:       return 4'(SLOT_MAC1);
            WORD_MAC2:       return 4'(SLOT_MAC2);
            WORD_INIT_CTRL1: return 4'(SLOT_INIT_CTRL1);
            WORD_SUBSYS_ID:  return 4'(SLOT_SUBSYS_ID);
            WORD_SUBSYS_VEN: return 4'(SLOT_SUBSYS_VEN);
            WORD_DEV_ID:     return 4'(SLOT_DEV_ID);
            WORD_VEN_ID:     return 4'(SLOT_VEN_ID);
            WORD_INIT_CTRL2: return 4'(SLOT_INIT_CTRL2);
            default:         return SLOT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/eeprom_autoload.sv
// Post-reset EEPROM auto-load: reads words 0..WORDS-1 through the shift
// engine's EERD port, keeps the MAC/init words, checks the image sum, then
// serves host EERD reads on the same port.
module eeprom_autoload
    import e1000_eeprom_pkg::*;
#(
    parameter int          WORDS    = 64,
    parameter logic [15:0] CHECKSUM = CHECKSUM_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        eni,
    output logic [31:0] wdatai,
    input  logic        eerd_busy,
    input  logic        eecd_busy,
    input  logic [31:0] rdatao,
    input  logic        host_eerd_wr,
    input  logic [31:0] host_eerd_wdata,
    output logic [31:0] host_eerd_rdata,
    output logic [47:0] mac_addr,
    output logic [15:0] init_ctrl1,
    output logic [15:0] subsys_id,
    output logic [15:0] subsys_ven,
    output logic [15:0] dev_id,
    output logic [15:0] ven_id,
    output logic [15:0] init_ctrl2,
    output logic        autoload_done,
    output logic        checksum_ok
);

    localparam logic [7:0] LAST_IDX = 8'(WORDS - 1);

    eeprom_state_e state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] sum_q, sum_d;
    logic        eni_q, eni_d;
    logic [31:0] wdatai_q, wdatai_d;
    logic        first_q, first_d;      // first cycle of an ACK wait
    logic        stale_q, stale_d;      // engine was still busy from an older read
    logic        pend_valid_q, pend_valid_d;
    logic [7:0]  pend_addr_q, pend_addr_d;
    logic [7:0]  host_addr_q, host_addr_d;
    logic [31:0] host_rdata_q, host_rdata_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic [15:0] res_q [NUM_RESULTS];
    logic [15:0] res_d [NUM_RESULTS];

    logic        store_en;
    logic [3:0]  store_slot;
    logic        host_start;
    logic [7:0]  host_req_addr;
    logic [15:0] rd_word;

    // eecd_busy only stalls the engine itself; while it holds, eni simply
    // stays up in the ACK state. The remaining bits are not part of EERD.
    logic unused_inputs;
    assign unused_inputs = ^{eecd_busy, rdatao[15:0],
                             host_eerd_wdata[31:16], host_eerd_wdata[7:1]};

    assign host_start    = host_eerd_wr & host_eerd_wdata[EERD_START_BIT];
    assign host_req_addr = host_eerd_wdata[EERD_ADDR_MSB:EERD_ADDR_LSB];
    assign rd_word       = rdatao[EERD_DATA_MSB:EERD_DATA_LSB];
    assign store_slot    = result_slot(idx_q);

    // Per-slot result update: only auto-load captures ever write these
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RESULTS; gi++) begin : g_result
            assign res_d[gi] = (store_en && store_slot == 4'(gi)) ? rd_word : res_q[gi];
        end
    endgenerate

    // Next-state logic for the load/host FSM, pending slot and sum
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        eni_d        = eni_q;
        wdatai_d     = wdatai_q;
        first_d      = 1'b0;
        stale_d      = stale_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        host_addr_d  = host_addr_q;
        host_rdata_d = host_rdata_q;
        done_d       = done_q;
        ok_d         = ok_q;
        store_en     = 1'b0;

        // Host requests outside IDLE park in the single pending slot, last wins
        if (host_start && state_q != IDLE) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = host_req_addr;
        end

        case (state_q)
            AL_ISSUE, H_ISSUE: begin
                wdatai_d = '0;
                wdatai_d[EERD_ADDR_MSB:EERD_ADDR_LSB] =
                    (state_q == AL_ISSUE) ? idx_q : host_addr_q;
                eni_d   = 1'b1;
                first_d = 1'b1;
                stale_d = 1'b0;
                state_d = (state_q == AL_ISSUE) ? AL_ACK : H_ACK;
            end

            AL_ACK, H_ACK: begin
                if (first_q && eerd_busy) begin
                    // Busy before our request could have been seen: an older
                    // read. Pull eni until it finishes so ours starts fresh.
                    stale_d = 1'b1;
                    eni_d   = 1'b0;
                end else if (stale_q) begin
                    if (!eerd_busy) begin
                        stale_d = 1'b0;
                        eni_d   = 1'b1;
                        first_d = 1'b1;
                    end
                end else if (eerd_busy) begin
                    eni_d   = 1'b0;
                    state_d = (state_q == AL_ACK) ? AL_WAIT : H_WAIT;
                end
            end

            AL_WAIT: begin
                if (!eerd_busy) begin
                    sum_d    = sum_q + rd_word;
                    store_en = (store_slot != SLOT_NONE);
                    state_d  = AL_NEXT;
                end
            end

            AL_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    ok_d    = (sum_q == CHECKSUM);
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = AL_ISSUE;
                end
            end

            IDLE: begin
                if (host_start || pend_valid_q) begin
                    // A write arriving now is newer than anything pending
                    host_addr_d  = host_start ? host_req_addr : pend_addr_q;
                    pend_valid_d = 1'b0;
                    host_rdata_d[EERD_DONE_BIT] = 1'b0;
                    state_d      = H_ISSUE;
                end
            end

            H_WAIT: begin
                if (!eerd_busy) begin
                    host_rdata_d = '0;
                    host_rdata_d[EERD_DATA_MSB:EERD_DATA_LSB] = rd_word;
                    host_rdata_d[EERD_ADDR_MSB:EERD_ADDR_LSB] = host_addr_q;
                    host_rdata_d[EERD_DONE_BIT] = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and registered outputs; reset restarts the pass at word 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= AL_ISSUE;
            idx_q        <= '0;
            sum_q        <= '0;
            eni_q        <= 1'b0;
            wdatai_q     <= '0;
            first_q      <= 1'b0;
            stale_q      <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            host_addr_q  <= '0;
            host_rdata_q <= '0;
            done_q       <= 1'b0;
            ok_q         <= 1'b0;
            res_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            eni_q        <= eni_d;
            wdatai_q     <= wdatai_d;
            first_q      <= first_d;
            stale_q      <= stale_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            host_addr_q  <= host_addr_d;
            host_rdata_q <= host_rdata_d;
            done_q       <= done_d;
            ok_q         <= ok_d;
            res_q        <= res_d;
        end
    end

    assign eni             = eni_q;
    assign wdatai          = wdatai_q;
    assign host_eerd_rdata = host_rdata_q;
    assign autoload_done   = done_q;
    assign checksum_ok     = ok_q;
    assign mac_addr        = {res_q[SLOT_MAC2], res_q[SLOT_MAC1], res_q[SLOT_MAC0]};
    assign init_ctrl1      = res_q[SLOT_INIT_CTRL1];
    assign subsys_id       = res_q[SLOT_SUBSYS_ID];
    assign subsys_ven      = res_q[SLOT_SUBSYS_VEN];
    assign dev_id          = res_q[SLOT_DEV_ID];
    assign ven_id          = res_q[SLOT_VEN_ID];
    assign init_ctrl2      = res_q[SLOT_INIT_CTRL2];

endmodule
